nco_sweep_ctrl: RTL and testbench

//  Sequencer for the NCO phase accumulator: drives its En and FCW inputs.

---
 rtl/nco_pkg.sv | 26 ++
 rtl/nco_dwell_timer.sv | 26 ++
 rtl/nco_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO sweep sequencer: widths, FSM states,
// config register map and the position of the LOOP flag in the NSTEPS word.
package nco_pkg;

  localparam int NCO_FCW_W   = 20;
  localparam int NCO_DWELL_W = 16;
  localparam int NCO_STEPS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_START  = 2'd0;
  localparam logic [1:0] ADDR_STEP   = 2'd1;
  localparam logic [1:0] ADDR_DWELL  = 2'd2;
  localparam logic [1:0] ADDR_NSTEPS = 2'd3;

  // LOOP lives in the MSB of the config data word.
  function automatic int loop_bit_pos(input int fcw_w);
    return fcw_w - 1;
  endfunction

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable down-counter that stops at zero; zero flags the last cycle of a dwell.
module nco_dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= value;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - DWELL_W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sweep sequencer for the NCO phase accumulator: steps FCW linearly from a
// programmed start value, holding each word for DWELL+1 cycles.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int FCW_W   = NCO_FCW_W,
  parameter int DWELL_W = NCO_DWELL_W,
  parameter int STEPS_W = NCO_STEPS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [FCW_W-1:0]   cfg_wdata,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic               En,
  output logic [FCW_W-1:0]   FCW,
  output logic [STEPS_W-1:0] step_idx
);

  localparam int LOOP_POS = loop_bit_pos(FCW_W);

  state_t               state_reg, state_next;
  logic                 en_reg, en_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [FCW_W-1:0]     fcw_reg, fcw_next;
  logic [STEPS_W-1:0]   idx_reg, idx_next;
  logic                 dwell_load;
  logic                 dwell_zero;

  logic [FCW_W-1:0]     fcw_start_reg;
  logic [FCW_W-1:0]     fcw_step_reg;
  logic [DWELL_W-1:0]   dwell_reg;
  logic [STEPS_W-1:0]   nsteps_reg;
  logic                 loop_reg;

  // Config is frozen while a sweep is in progress so the sequence stays coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcw_start_reg <= '0;
      fcw_step_reg  <= '0;
      dwell_reg     <= '0;
      nsteps_reg    <= '0;
      loop_reg      <= 1'b0;
    end else if (cfg_we && !busy_reg) begin
      case (cfg_addr)
        ADDR_START:  fcw_start_reg <= cfg_wdata;
        ADDR_STEP:   fcw_step_reg  <= cfg_wdata;
        ADDR_DWELL:  dwell_reg     <= cfg_wdata[DWELL_W-1:0];
        ADDR_NSTEPS: begin
          nsteps_reg <= cfg_wdata[STEPS_W-1:0];
          loop_reg   <= cfg_wdata[LOOP_POS];
        end
        default: ;
      endcase
    end
  end

  nco_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .load  (dwell_load),
    .value (dwell_reg),
    .zero  (dwell_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      fcw_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      fcw_reg   <= fcw_next;
      idx_reg   <= idx_next;
    end
  end

  // Outputs are computed one cycle ahead so busy/done/En/FCW leave the block registered.
  always_comb begin
    state_next = state_reg;
    en_next    = en_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    fcw_next   = fcw_reg;
    idx_next   = idx_reg;
    dwell_load = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        en_next = 1'b0;
        if (start && !stop) begin
          state_next = ST_LOAD;
          busy_next  = 1'b1;
        end
      end

      ST_LOAD: begin
        if (stop) begin
          state_next = ST_IDLE;
          en_next    = 1'b0;
        end else begin
          state_next = ST_RUN;
          busy_next  = 1'b1;
          en_next    = 1'b1;
          fcw_next   = fcw_start_reg;
          idx_next   = '0;
          dwell_load = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_next = ST_IDLE;
          en_next    = 1'b0;
        end else if (!dwell_zero) begin
          busy_next = 1'b1;
        end else if (idx_reg < nsteps_reg) begin
          busy_next  = 1'b1;
          fcw_next   = fcw_reg + fcw_step_reg;
          idx_next   = idx_reg + STEPS_W'(1);
          dwell_load = 1'b1;
        end else if (loop_reg) begin
          busy_next  = 1'b1;
          fcw_next   = fcw_start_reg;
          idx_next   = '0;
          dwell_load = 1'b1;
        end else begin
          state_next = ST_DONE;
          en_next    = 1'b0;
          done_next  = 1'b1;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        en_next    = 1'b0;
      end
    endcase
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign En       = en_reg;
  assign FCW      = fcw_reg;
  assign step_idx = idx_reg;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected FCW/step_idx per enabled cycle are
// queued by the stimulus; a negedge monitor pops and compares them.
module tb_nco_sweep_ctrl;
  import nco_pkg::*;

  localparam int FW = 20;
  localparam int DW = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [FW-1:0] cfg_wdata = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy, done, En;
  logic [FW-1:0] FCW;
  logic [SW-1:0] step_idx;

  typedef struct packed {
    logic [FW-1:0] fcw;
    logic [SW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_exp = 0;
  int   done_seen = 0;
  int   en_cycles = 0;
  int   busy_cycles = 0;
  logic mon_en = 1'b0;
  logic prev_en = 1'b0;

  nco_sweep_ctrl #(.FCW_W(FW), .DWELL_W(DW), .STEPS_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .En        (En),
    .FCW       (FCW),
    .step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  // Monitor: every enabled cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (En) begin
        en_cycles++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL en_extra: FCW=%05h step_idx=%0d, required En=0", FCW, step_idx);
        end else begin
          mon_e = exp_q.pop_front();
          if (FCW !== mon_e.fcw || step_idx !== mon_e.idx) begin
            failures++;
            $display("FAIL fcw_step: FCW=%05h step_idx=%0d, required FCW=%05h step_idx=%0d",
                     FCW, step_idx, mon_e.fcw, mon_e.idx);
          end
        end
      end
      if (done) begin
        done_seen++;
        checks++;
        if (done_exp == 0) begin
          failures++;
          $display("FAIL done_extra: done=1 En=%0b, required no done pulse", En);
        end else if (En || !prev_en) begin
          failures++;
          $display("FAIL done_timing: En=%0b prev_En=%0b, required En=0 prev_En=1", En, prev_en);
        end else begin
          done_exp--;
        end
      end
      if (busy) busy_cycles++;
    end
    prev_en <= En;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cfg(input logic [1:0] a, input logic [FW-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick;
    cfg_we    = 1'b0;
  endtask

  task automatic load_cfg(input logic [FW-1:0] st, input logic [FW-1:0] sp,
                          input int dw, input logic [SW-1:0] ns, input logic lp);
    cfg(ADDR_START, st);
    cfg(ADDR_STEP, sp);
    cfg(ADDR_DWELL, FW'(dw));
    cfg(ADDR_NSTEPS, {lp, {(FW-1-SW){1'b0}}, ns});
  endtask

  task automatic push_exp(input logic [FW-1:0] f, input int idx);
    exp_t e;
    e.fcw = f;
    e.idx = SW'(idx);
    exp_q.push_back(e);
  endtask

  // One-shot sweep; spam re-asserts start while busy and in the DONE cycle.
  task automatic run_oneshot(input string name, input bit do_cfg,
                             input logic [FW-1:0] st, input logic [FW-1:0] sp,
                             input int dw, input int ns, input bit spam);
    logic [FW-1:0] f;
    int            n;
    bit            seen_end;
    if (do_cfg) load_cfg(st, sp, dw, SW'(ns), 1'b0);
    f = st;
    n = (ns + 1) * (dw + 1);
    for (int i = 0; i <= ns; i++) begin
      for (int j = 0; j <= dw; j++) push_exp(f, i);
      f = f + sp;
    end
    done_exp    = 1;
    done_seen   = 0;
    en_cycles   = 0;
    busy_cycles = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    seen_end = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick;
      if (!busy && !done) begin
        start    = 1'b0;
        seen_end = 1'b1;
        break;
      end
      start = spam;
    end
    start = 1'b0;
    chk({name, "_timeout"}, 32'(seen_end), 32'd1);
    repeat (3) tick;
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_en_cycles"}, 32'(en_cycles), 32'(n));
    chk({name, "_busy_cycles"}, 32'(busy_cycles), 32'(n + 1));
    chk({name, "_done_count"}, 32'(done_seen), 32'd1);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    $display("sweep %s: en_cycles=%0d busy_cycles=%0d done_pulses=%0d",
             name, en_cycles, busy_cycles, done_seen);
    exp_q.delete();
    done_exp = 0;
  endtask

  initial begin
    // Power-on reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 32'(En), 32'd0);
    chk("rst_fcw", 32'(FCW), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_step_idx", 32'(step_idx), 32'd0);
    rst = 1'b0;
    tick;

    // Reset asserted mid-cycle during a sweep clears outputs without a clock edge.
    load_cfg(20'h12345, 20'h00111, 2, 8'd5, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (6) tick;
    chk("pre_reset_en", 32'(En), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en", 32'(En), 32'd0);
    chk("async_rst_fcw", 32'(FCW), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_step_idx", 32'(step_idx), 32'd0);
    $display("reset mid-sweep: En=%0b FCW=%05h busy=%0b", En, FCW, busy);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick;
    mon_en = 1'b1;

    // Config cleared by reset: a sweep without writes shows FCW=0 for one cycle.
    run_oneshot("after_reset", 1'b0, 20'h00000, 20'h00000, 0, 0, 1'b0);

    run_oneshot("single", 1'b1, 20'h80000, 20'h00000, 3, 0, 1'b0);
    run_oneshot("ramp", 1'b1, 20'h10000, 20'h08000, 1, 3, 1'b0);
    run_oneshot("wrap", 1'b1, 20'hFFFF0, 20'h00020, 0, 1, 1'b0);
    run_oneshot("neg_step", 1'b1, 20'h00001, 20'hFFFFF, 0, 1, 1'b0);
    run_oneshot("start_busy", 1'b1, 20'h00100, 20'h00010, 2, 2, 1'b1);

    // Looping sweep with locked config, then aborted by stop.
    load_cfg(20'h20000, 20'h20000, 0, 8'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      push_exp(20'h20000, 0);
      push_exp(20'h40000, 1);
    end
    en_cycles = 0;
    done_seen = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    cfg(ADDR_START, 20'h12345);
    cfg(ADDR_STEP, 20'h00001);
    repeat (3) tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("loop_stop_en", 32'(En), 32'd0);
    chk("loop_stop_busy", 32'(busy), 32'd0);
    chk("loop_stop_done", 32'(done), 32'd0);
    repeat (3) tick;
    chk("loop_en_cycles", 32'(en_cycles), 32'd6);
    chk("loop_done_count", 32'(done_seen), 32'd0);
    chk("loop_queue_left", 32'(exp_q.size()), 32'd0);
    $display("loop sweep: en_cycles=%0d stopped", en_cycles);
    exp_q.delete();

    // stop on the final dwell cycle suppresses done.
    load_cfg(20'h30000, 20'h00100, 1, 8'd1, 1'b0);
    push_exp(20'h30000, 0);
    push_exp(20'h30000, 0);
    push_exp(20'h30100, 1);
    push_exp(20'h30100, 1);
    en_cycles = 0;
    done_seen = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_end_en", 32'(En), 32'd0);
    chk("stop_end_busy", 32'(busy), 32'd0);
    repeat (3) tick;
    chk("stop_end_en_cycles", 32'(en_cycles), 32'd4);
    chk("stop_end_done_count", 32'(done_seen), 32'd0);
    chk("stop_end_queue_left", 32'(exp_q.size()), 32'd0);
    $display("stop at end: en_cycles=%0d done_pulses=%0d", en_cycles, done_seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
